pipe_hazard_unit: RTL and testbench

PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

---
 rtl/pipe_hazard_unit_pkg.sv | 40 ++++
 rtl/pipe_hazard_unit_if.sv | 52 +++++
 rtl/hazard_sb_entry_match.sv | 19 +
 rtl/pipe_hazard_unit.sv | 159 +++++++++++++++
 tb/tb_pipe_hazard_unit.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard unit.
//   - result latency classes carried with each ID instruction
//   - forward-select value that means "use the register file"
//   - scoreboard entry layout shared by the top and the entry matcher
package pipe_hazard_unit_pkg;

  // Widest register address and ready counter an entry can hold; the top
  // checks its parameters against these at elaboration.
  localparam int RA_W_MAX = 8;
  localparam int RDY_W    = 4;

  localparam int FWD_REGFILE = 0;

  typedef enum logic [1:0] {
    LAT_ALU  = 2'd0,
    LAT_LOAD = 2'd1,
    LAT_MUL  = 2'd2,
    LAT_RSVD = 2'd3
  } lat_e;

  typedef struct packed {
    logic                valid;
    logic                wen;
    logic [RA_W_MAX-1:0] addr;
    logic [RDY_W-1:0]    ready;
  } sb_entry_t;

  // Cycles until forwardable for an instruction entering EXE; the reserved
  // class behaves like a plain ALU result.
  function automatic logic [RDY_W-1:0] ready_init(input lat_e lat,
                                                  input int   load_lat,
                                                  input int   mul_lat);
    case (lat)
      LAT_LOAD: return RDY_W'(load_lat);
      LAT_MUL:  return RDY_W'(mul_lat);
      default:  return '0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// Bundle between the pipeline control path and the hazard unit.
//   master : pipeline side, drives the ID instruction description, redirect
//            and debug controls; receives enables, flushes, forward selects
//            and the stall counter.
//   slave  : hazard unit side (directions mirrored).
interface pipe_hazard_unit_if
  import pipe_hazard_unit_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  logic            id_valid;
  logic [RA_W-1:0] id_rs_addr;
  logic [RA_W-1:0] id_rt_addr;
  logic            id_rs_used;
  logic            id_rt_used;
  logic            id_wen;
  logic [RA_W-1:0] id_wb_addr;
  lat_e            id_lat;
  logic            redirect;
  logic            debug_en;
  logic            debug_step;

  logic             if_en;
  logic             id_en;
  logic             exe_en;
  logic             mem_en;
  logic             wb_en;
  logic             id_rst;
  logic             exe_rst;
  logic [SEL_W-1:0] fwd_a_sel;
  logic [SEL_W-1:0] fwd_b_sel;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
           id_wen, id_wb_addr, id_lat, redirect, debug_en, debug_step,
    input  if_en, id_en, exe_en, mem_en, wb_en, id_rst, exe_rst,
           fwd_a_sel, fwd_b_sel, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
           id_wen, id_wb_addr, id_lat, redirect, debug_en, debug_step,
    output if_en, id_en, exe_en, mem_en, wb_en, id_rst, exe_rst,
           fwd_a_sel, fwd_b_sel, stall_cnt
  );

endinterface

// File: rtl/hazard_sb_entry_match.sv
// Compares one scoreboard entry against one source register address.
//   entry_i      : scoreboard entry
//   src_i        : source register address (zero-extended)
//   hit_o        : entry is a live register write to that address (r0 never hits)
//   ready_zero_o : entry result is forwardable this cycle
module hazard_sb_entry_match
  import pipe_hazard_unit_pkg::*;
(
  input  sb_entry_t           entry_i,
  input  logic [RA_W_MAX-1:0] src_i,
  output logic                hit_o,
  output logic                ready_zero_o
);

  assign hit_o = entry_i.valid & entry_i.wen &
                 (entry_i.addr == src_i) & (entry_i.addr != '0);
  assign ready_zero_o = (entry_i.ready == '0);

endmodule

// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard unit: tracks in-flight register writes in a DEPTH-entry
// scoreboard (entry 0 = EXE), selects forwarding sources for the two ID
// operands, stalls ID on not-yet-ready results, handles redirect flushes,
// single-step debug holds, and counts stall cycles (saturating).
//   clk, rst : clock, synchronous active-high reset
//   hif      : slave side of pipe_hazard_unit_if (ID description, redirect,
//              debug in; stage enables, flushes, forward selects, stall_cnt out)
module pipe_hazard_unit
  import pipe_hazard_unit_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 2,
  parameter int CNT_W    = 16,
  parameter int RA_W     = 5
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_unit_if.slave hif
);

  localparam int SEL_W = $clog2(DEPTH + 1);

  if (LOAD_LAT >= DEPTH || MUL_LAT >= DEPTH) begin : g_bad_lat
    $error("pipe_hazard_unit: LOAD_LAT and MUL_LAT must be below DEPTH");
  end
  if (RA_W > RA_W_MAX || DEPTH > (1 << RDY_W)) begin : g_bad_width
    $error("pipe_hazard_unit: RA_W or DEPTH exceeds scoreboard entry fields");
  end

  sb_entry_t [DEPTH-1:0] sb_q, sb_d;
  logic                  dbg_step_q;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

  logic [DEPTH-1:0]      hit_a, rz_a, hit_b, rz_b;
  logic [RA_W_MAX-1:0]   src_a, src_b;
  logic [SEL_W-1:0]      sel_a, sel_b;
  logic                  nr_a, nr_b;
  logic                  step_edge, hold, stall;

  assign src_a = RA_W_MAX'(hif.id_rs_addr);
  assign src_b = RA_W_MAX'(hif.id_rt_addr);

  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    hazard_sb_entry_match u_match_a (
      .entry_i      (sb_q[i]),
      .src_i        (src_a),
      .hit_o        (hit_a[i]),
      .ready_zero_o (rz_a[i])
    );
    hazard_sb_entry_match u_match_b (
      .entry_i      (sb_q[i]),
      .src_i        (src_b),
      .hit_o        (hit_b[i]),
      .ready_zero_o (rz_b[i])
    );
  end

  function automatic sb_entry_t age_entry(input sb_entry_t e);
    age_entry = e;
    if (e.ready != '0) age_entry.ready = e.ready - RDY_W'(1);
  endfunction

  // Scan oldest to youngest so the nearest hit is the one left standing;
  // a ready younger write therefore shadows an older pending one.
  always_comb begin
    sel_a = SEL_W'(FWD_REGFILE);
    sel_b = SEL_W'(FWD_REGFILE);
    nr_a  = 1'b0;
    nr_b  = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (hit_a[i]) begin
        sel_a = rz_a[i] ? SEL_W'(i + 1) : SEL_W'(FWD_REGFILE);
        nr_a  = ~rz_a[i];
      end
      if (hit_b[i]) begin
        sel_b = rz_b[i] ? SEL_W'(i + 1) : SEL_W'(FWD_REGFILE);
        nr_b  = ~rz_b[i];
      end
    end
    if (!hif.id_rs_used) begin
      sel_a = SEL_W'(FWD_REGFILE);
      nr_a  = 1'b0;
    end
    if (!hif.id_rt_used) begin
      sel_b = SEL_W'(FWD_REGFILE);
      nr_b  = 1'b0;
    end
  end

  // Debug hold freezes everything except on the cycle after a 0->1 step edge.
  assign step_edge = hif.debug_step & ~dbg_step_q;
  assign hold      = hif.debug_en & ~step_edge;
  assign stall     = ~rst & ~hold & ~hif.redirect & (nr_a | nr_b);

  always_comb begin
    hif.if_en     = 1'b1;
    hif.id_en     = 1'b1;
    hif.exe_en    = 1'b1;
    hif.mem_en    = 1'b1;
    hif.wb_en     = 1'b1;
    hif.id_rst    = 1'b0;
    hif.exe_rst   = 1'b0;
    hif.fwd_a_sel = sel_a;
    hif.fwd_b_sel = sel_b;
    if (rst) begin
      hif.id_rst    = 1'b1;
      hif.exe_rst   = 1'b1;
      hif.fwd_a_sel = SEL_W'(FWD_REGFILE);
      hif.fwd_b_sel = SEL_W'(FWD_REGFILE);
    end else if (hold) begin
      hif.if_en  = 1'b0;
      hif.id_en  = 1'b0;
      hif.exe_en = 1'b0;
      hif.mem_en = 1'b0;
      hif.wb_en  = 1'b0;
    end else if (hif.redirect) begin
      hif.id_rst = 1'b1;
    end else if (stall) begin
      hif.if_en   = 1'b0;
      hif.id_en   = 1'b0;
      hif.exe_rst = 1'b1;
    end
  end

  assign hif.stall_cnt = stall_cnt_q;

  always_comb begin
    sb_d        = sb_q;
    stall_cnt_d = stall_cnt_q;
    if (!hold) begin
      for (int i = DEPTH - 1; i >= 1; i--) begin
        sb_d[i] = age_entry(sb_q[i-1]);
      end
      // A stalled or squashed ID instruction enters EXE as a bubble.
      sb_d[0] = '0;
      if (!stall && !hif.redirect && hif.id_valid) begin
        sb_d[0].valid = 1'b1;
        sb_d[0].wen   = hif.id_wen;
        sb_d[0].addr  = RA_W_MAX'(hif.id_wb_addr);
        sb_d[0].ready = ready_init(hif.id_lat, LOAD_LAT, MUL_LAT);
      end
    end
    if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // Reset clears only the valid bits; stale payload in invalid entries never hits.
  always_ff @(posedge clk) begin
    sb_q        <= sb_d;
    dbg_step_q  <= hif.debug_step;
    stall_cnt_q <= stall_cnt_d;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sb_q[i].valid <= 1'b0;
      dbg_step_q  <= 1'b0;
      stall_cnt_q <= '0;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
module tb_pipe_hazard_unit;
  import pipe_hazard_unit_pkg::*;

  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 1;
  localparam int MUL_LAT  = 2;
  localparam int CNT_W    = 8;
  localparam int RA_W     = 5;
  localparam int CMAX     = (1 << CNT_W) - 1;
  localparam int SAT_TGT  = (1 << CNT_W) + 3;

  // {if_en,id_en,exe_en,mem_en,wb_en,id_rst,exe_rst}
  localparam logic [6:0] C_RST   = 7'b1111111;
  localparam logic [6:0] C_NORM  = 7'b1111100;
  localparam logic [6:0] C_STALL = 7'b0011101;
  localparam logic [6:0] C_REDIR = 7'b1111110;
  localparam logic [6:0] C_HOLD  = 7'b0000000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_unit_if #(.DEPTH(DEPTH), .RA_W(RA_W), .CNT_W(CNT_W)) hif ();

  pipe_hazard_unit #(
    .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .MUL_LAT(MUL_LAT),
    .CNT_W(CNT_W), .RA_W(RA_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hif (hif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: each in-flight write is stamped with the advance count
  // at which it entered EXE; its age gives its stage, and it is forwardable
  // once age >= its latency.
  typedef struct { int stamp; int addr; int lat; } rec_t;
  rec_t q[$];
  int   adv   = 0;
  int   mcnt  = 0;
  bit   mprev = 1'b0;

  logic [6:0] e_ctl;
  int         e_fa, e_fb;
  bit         e_hold, e_stall;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", nm, act, req);
    end
  endtask

  function automatic logic [6:0] act_ctl();
    return {hif.if_en, hif.id_en, hif.exe_en, hif.mem_en, hif.wb_en, hif.id_rst, hif.exe_rst};
  endfunction

  function automatic void lookup(input int src, input bit used, output int sel, output bit nr);
    int best = DEPTH;
    int blat = 0;
    sel = 0;
    nr  = 1'b0;
    if (!used || src == 0) return;
    foreach (q[k]) begin
      int age = adv - q[k].stamp;
      if (age < DEPTH && q[k].addr == src && age < best) begin
        best = age;
        blat = q[k].lat;
      end
    end
    if (best == DEPTH) return;
    if (blat <= best) sel = best + 1;
    else nr = 1'b1;
  endfunction

  task automatic model_eval();
    int sa, sb;
    bit na, nb;
    e_hold = hif.debug_en && !(hif.debug_step && !mprev);
    lookup(int'(hif.id_rs_addr), hif.id_rs_used, sa, na);
    lookup(int'(hif.id_rt_addr), hif.id_rt_used, sb, nb);
    e_stall = !rst && !e_hold && !hif.redirect && (na || nb);
    e_fa = sa;
    e_fb = sb;
    if (rst) begin
      e_ctl = C_RST; e_fa = 0; e_fb = 0;
    end else if (e_hold) e_ctl = C_HOLD;
    else if (hif.redirect) e_ctl = C_REDIR;
    else if (e_stall) e_ctl = C_STALL;
    else e_ctl = C_NORM;
  endtask

  task automatic model_commit();
    int l;
    if (rst) begin
      q.delete();
      mcnt  = 0;
      mprev = 1'b0;
    end else begin
      if (!e_hold) begin
        adv++;
        if (!e_stall && !hif.redirect && hif.id_valid && hif.id_wen) begin
          l = int'(hif.id_lat);
          q.push_back('{adv, int'(hif.id_wb_addr), (l == 1) ? LOAD_LAT : (l == 2) ? MUL_LAT : 0});
        end
      end
      if (e_stall && mcnt < CMAX) mcnt++;
      mprev = hif.debug_step;
      while (q.size() > 0 && adv - q[0].stamp >= DEPTH) void'(q.pop_front());
    end
  endtask

  task automatic drive(input bit r, input bit vld, input bit wen, input int wb, input int lat,
                       input int rs, input bit rsu, input int rt, input bit rtu,
                       input bit redir, input bit den, input bit dstep);
    rst            = r;
    hif.id_valid   = vld;
    hif.id_wen     = wen;
    hif.id_wb_addr = RA_W'(wb);
    hif.id_lat     = lat_e'(lat[1:0]);
    hif.id_rs_addr = RA_W'(rs);
    hif.id_rs_used = rsu;
    hif.id_rt_addr = RA_W'(rt);
    hif.id_rt_used = rtu;
    hif.redirect   = redir;
    hif.debug_en   = den;
    hif.debug_step = dstep;
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic step();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, " ctl"}, 32'(act_ctl()), 32'(e_ctl));
    chk({tag, " fwd_a"}, 32'(hif.fwd_a_sel), e_fa);
    chk({tag, " fwd_b"}, 32'(hif.fwd_b_sel), e_fb);
    chk({tag, " stall_cnt"}, 32'(hif.stall_cnt), mcnt);
  endtask

  // Dependent multi-cycle chain: each instruction reads the previous one's
  // destination, so every instruction stalls ID for MUL_LAT cycles.
  task automatic chain(input bit r, input int k);
    drive(r, 1, 1, 1 + (k % 2), 2, (k == 0) ? 0 : 1 + ((k - 1) % 2), 1, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit r, vld, wen; int wb, lat, rs; bit rsu; int rt; bit rtu, redir, den, dstep;
    logic [6:0] ctl; int fa, fb, cnt;
  } vec_t;

  function automatic vec_t mk(bit r, bit vld, bit wen, int wb, int lat, int rs, bit rsu,
                              int rt, bit rtu, bit redir, bit den, bit dstep,
                              logic [6:0] ctl, int fa, int fb, int cnt);
    vec_t v;
    v = '{r, vld, wen, wb, lat, rs, rsu, rt, rtu, redir, den, dstep, ctl, fa, fb, cnt};
    return v;
  endfunction

  vec_t tbl[37];

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, nst, guard;
    bit found;

    //             r vld wen wb lat rs rsu rt rtu rd den st  ctl     fa fb cnt
    tbl[0]  = mk(1, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0, C_RST,   0, 0, 0);
    tbl[1]  = mk(0, 1, 1,  3, 0,  0, 0,  0, 0, 0, 0, 0, C_NORM,  0, 0, 0);
    tbl[2]  = mk(0, 1, 0,  0, 0,  3, 1,  0, 0, 0, 0, 0, C_NORM,  1, 0, 0);
    tbl[3]  = mk(0, 1, 1,  5, 1,  0, 0,  0, 0, 0, 0, 0, C_NORM,  0, 0, 0);
    tbl[4]  = mk(0, 1, 0,  0, 0,  5, 1,  0, 0, 0, 0, 0, C_STALL, 0, 0, 0);
    tbl[5]  = mk(0, 1, 0,  0, 0,  5, 1,  0, 0, 0, 0, 0, C_NORM,  2, 0, 1);
    tbl[6]  = mk(0, 1, 1,  7, 2,  0, 0,  0, 0, 0, 0, 0, C_NORM,  0, 0, 1);
    tbl[7]  = mk(0, 1, 0,  0, 0,  0, 0,  7, 1, 0, 0, 0, C_STALL, 0, 0, 1);
    tbl[8]  = mk(0, 1, 0,  0, 0,  0, 0,  7, 1, 0, 0, 0, C_STALL, 0, 0, 2);
    tbl[9]  = mk(0, 1, 0,  0, 0,  0, 0,  7, 1, 0, 0, 0, C_NORM,  0, 3, 3);
    tbl[10] = mk(0, 1, 1,  0, 2,  0, 0,  0, 0, 0, 0, 0, C_NORM,  0, 0, 3);
    tbl[11] = mk(0, 1, 0,  0, 0,  0, 1,  0, 1, 0, 0, 0, C_NORM,  0, 0, 3);
    tbl[12] = mk(0, 1, 1,  5, 1,  0, 0,  0, 0, 0, 0, 0, C_NORM,  0, 0, 3);
    tbl[13] = mk(0, 1, 0,  0, 0,  5, 1,  0, 0, 1, 0, 0, C_REDIR, 0, 0, 3);
    tbl[14] = mk(0, 1, 0,  0, 0,  5, 1,  0, 0, 0, 0, 0, C_NORM,  2, 0, 3);
    tbl[15] = mk(0, 1, 1,  9, 3,  0, 0,  0, 0, 0, 0, 0, C_NORM,  0, 0, 3);
    tbl[16] = mk(0, 1, 0,  0, 0,  0, 0,  9, 1, 0, 0, 0, C_NORM,  0, 1, 3);
    tbl[17] = mk(0, 1, 1, 10, 2,  0, 0,  0, 0, 0, 0, 0, C_NORM,  0, 0, 3);
    tbl[18] = mk(0, 1, 1, 10, 0,  0, 0,  0, 0, 0, 0, 0, C_NORM,  0, 0, 3);
    tbl[19] = mk(0, 1, 0,  0, 0, 10, 1, 10, 1, 0, 0, 0, C_NORM,  1, 1, 3);
    tbl[20] = mk(0, 0, 1, 11, 0,  0, 0,  0, 0, 0, 0, 0, C_NORM,  0, 0, 3);
    tbl[21] = mk(0, 1, 0,  0, 0, 11, 1,  0, 0, 0, 0, 0, C_NORM,  0, 0, 3);
    tbl[22] = mk(0, 1, 1, 12, 0,  0, 0,  0, 0, 0, 0, 0, C_NORM,  0, 0, 3);
    tbl[23] = mk(0, 1, 0,  0, 0, 12, 0, 12, 0, 0, 0, 0, C_NORM,  0, 0, 3);
    tbl[24] = mk(0, 1, 1, 13, 0,  0, 0,  0, 0, 0, 0, 0, C_NORM,  0, 0, 3);
    tbl[25] = mk(0, 1, 0,  0, 0, 13, 1,  0, 0, 0, 1, 0, C_HOLD,  1, 0, 3);
    tbl[26] = mk(0, 1, 0,  0, 0, 13, 1,  0, 0, 0, 1, 1, C_NORM,  1, 0, 3);
    tbl[27] = mk(0, 1, 0,  0, 0, 13, 1,  0, 0, 0, 1, 1, C_HOLD,  2, 0, 3);
    tbl[28] = mk(0, 1, 0,  0, 0, 13, 1,  0, 0, 0, 1, 1, C_HOLD,  2, 0, 3);
    tbl[29] = mk(0, 1, 0,  0, 0, 13, 1,  0, 0, 0, 1, 0, C_HOLD,  2, 0, 3);
    tbl[30] = mk(0, 1, 0,  0, 0, 13, 1,  0, 0, 0, 1, 1, C_NORM,  2, 0, 3);
    tbl[31] = mk(0, 1, 0,  0, 0, 13, 1,  0, 0, 0, 1, 1, C_HOLD,  3, 0, 3);
    tbl[32] = mk(0, 1, 1, 14, 1,  0, 0,  0, 0, 0, 0, 0, C_NORM,  0, 0, 3);
    tbl[33] = mk(0, 1, 0,  0, 0, 14, 1,  0, 0, 0, 1, 0, C_HOLD,  0, 0, 3);
    tbl[34] = mk(0, 1, 0,  0, 0, 14, 1,  0, 0, 0, 1, 0, C_HOLD,  0, 0, 3);
    tbl[35] = mk(0, 1, 0,  0, 0, 14, 1,  0, 0, 0, 0, 0, C_STALL, 0, 0, 3);
    tbl[36] = mk(0, 1, 0,  0, 0, 14, 1,  0, 0, 0, 0, 0, C_NORM,  2, 0, 4);

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Directed vectors, compared against hand-derived constants.
    for (int i = 0; i < 37; i++) begin
      drive(tbl[i].r, tbl[i].vld, tbl[i].wen, tbl[i].wb, tbl[i].lat, tbl[i].rs, tbl[i].rsu,
            tbl[i].rt, tbl[i].rtu, tbl[i].redir, tbl[i].den, tbl[i].dstep);
      settle();
      chk($sformatf("row%0d ctl", i), 32'(act_ctl()), 32'(tbl[i].ctl));
      chk($sformatf("row%0d fwd_a", i), 32'(hif.fwd_a_sel), tbl[i].fa);
      chk($sformatf("row%0d fwd_b", i), 32'(hif.fwd_b_sel), tbl[i].fb);
      chk($sformatf("row%0d stall_cnt", i), 32'(hif.stall_cnt), tbl[i].cnt);
      step();
    end

    // Counter saturation with a continuously dependent instruction stream.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    cmp_model("sat_rst");
    step();
    k = 0; nst = 0; guard = 0;
    while (nst < SAT_TGT && guard < 4 * SAT_TGT + 50) begin
      chain(0, k);
      settle();
      cmp_model("sat");
      if (e_stall) nst++;
      else k++;
      step();
      guard++;
    end
    chk("sat_stall_cycles", nst, SAT_TGT);
    chk("sat_cnt_allones", 32'(hif.stall_cnt), CMAX);

    // Reset in the middle of a stall.
    found = 1'b0;
    guard = 0;
    while (!found && guard < 10) begin
      chain(0, k);
      settle();
      if (e_stall) found = 1'b1;
      else begin
        cmp_model("pre_rst");
        k++;
        step();
      end
      guard++;
    end
    chk("mid_stall_found", 32'(found), 1);
    chk("mid_stall_ctl", 32'(act_ctl()), 32'(C_STALL));
    chain(1, k);
    settle();
    chk("rst_ctl", 32'(act_ctl()), 32'(C_RST));
    chk("rst_fwd_a", 32'(hif.fwd_a_sel), 0);
    step();
    chain(0, k);
    settle();
    chk("post_rst_ctl", 32'(act_ctl()), 32'(C_NORM));
    chk("post_rst_cnt", 32'(hif.stall_cnt), 0);
    chk("post_rst_fwd_a", 32'(hif.fwd_a_sel), 0);
    step();

    // Randomized traffic against the reference model.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    cmp_model("rnd_rst");
    step();
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
      settle();
      cmp_model($sformatf("rnd%0d", i));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
